// File: rtl/cpu_mreg.sv
// cpu_mreg -- status-flag register of the one-cycle CPU.
//
// Holds the Carry (C), Zero (Z) and Borrow (B) flags produced by the ALU so
// that the following instruction (conditional branch, add-with-carry,
// subtract-with-borrow) sees the flags of the previous one. Every rising
// clock edge loads all three flags; there is no enable.
//
// Parameters:
//   RST_C, RST_Z, RST_B  values forced onto C, Z, B while reset is asserted
//
// Ports:
//   CLK  in   system clock, capture on rising edge
//   RST  in   asynchronous active-low reset
//   Cin  in   carry flag from ALU
//   Zin  in   zero flag from ALU
//   Bin  in   borrow flag from ALU
//   C    out  registered carry flag
//   Z    out  registered zero flag
//   B    out  registered borrow flag
module cpu_mreg #(
  parameter logic RST_C = 1'b0,
  parameter logic RST_Z = 1'b0,
  parameter logic RST_B = 1'b0
) (
  input  logic CLK,
  input  logic RST,
  input  logic Cin,
  input  logic Zin,
  input  logic Bin,
  output logic C,
  output logic Z,
  output logic B
);

  logic c_p0;
  logic z_p0;
  logic b_p0;

  // Stage p0: ALU flags -> flag flops. Reset acts without a clock and
  // overrides capture for as long as it is held low.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      c_p0 <= RST_C;
      z_p0 <= RST_Z;
      b_p0 <= RST_B;
    end else begin
      c_p0 <= Cin;
      z_p0 <= Zin;
      b_p0 <= Bin;
    end
  end

  // Outputs come straight from the flops: no input-to-output logic path.
  assign C = c_p0;
  assign Z = z_p0;
  assign B = b_p0;

endmodule

// File: tb/tb_cpu_mreg.sv
// Directed-vector bench for cpu_mreg. Each vector gives reset level, the
// {Cin,Zin,Bin} inputs and the hand-computed {C,Z,B} expected after the
// next rising edge. Expected post-edge values go into a queue that a
// separate monitor pops and compares just after each rising edge. Between
// edges the stimulus side also checks that outputs did not react to input
// changes (or dropped to the reset value at once when reset was asserted).
module tb_cpu_mreg;

  logic CLK;
  logic RST;
  logic Cin;
  logic Zin;
  logic Bin;
  logic C;
  logic Z;
  logic B;

  int errors = 0;
  int checks = 0;

  logic [2:0] exp_q[$];
  logic [2:0] prev_exp;
  string      name_q[$];
  string      cur_name;

  cpu_mreg dut (
    .CLK (CLK),
    .RST (RST),
    .Cin (Cin),
    .Zin (Zin),
    .Bin (Bin),
    .C   (C),
    .Z   (Z),
    .B   (B)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Drive one vector at the falling edge, check the between-edge output,
  // and queue the expected post-edge value for the monitor.
  task automatic step(input logic r, input logic [2:0] in, input logic [2:0] exp);
    logic [2:0] imm;
    @(negedge CLK);
    RST = r;
    {Cin, Zin, Bin} = in;
    #1;
    imm = r ? prev_exp : 3'b000;
    checks++;
    if ({C, Z, B} !== imm) begin
      errors++;
      $display("FAIL %s between-edge: got CZB=%b required %b", cur_name, {C, Z, B}, imm);
    end
    exp_q.push_back(exp);
    name_q.push_back(cur_name);
    prev_exp = exp;
  endtask

  // Monitor: the register updates on every edge, so every queued
  // expectation belongs to the edge right after it was issued.
  initial begin
    logic [2:0] e;
    string      n;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        checks++;
        if ({C, Z, B} !== e) begin
          errors++;
          $display("FAIL %s post-edge: got CZB=%b required %b", n, {C, Z, B}, e);
        end
      end
    end
  end

  initial begin
    int waited;
    RST = 1'b0;
    Cin = 1'b0;
    Zin = 1'b0;
    Bin = 1'b0;
    prev_exp = 3'b000;

    // Reset held, then release and idle.
    cur_name = "reset";
    repeat (2) step(1'b0, 3'b000, 3'b000);
    cur_name = "idle";
    repeat (3) step(1'b1, 3'b000, 3'b000);

    // Carry pulse.
    cur_name = "carry";
    repeat (2) step(1'b1, 3'b100, 3'b100);
    repeat (2) step(1'b1, 3'b000, 3'b000);

    // Borrow pulse.
    cur_name = "borrow";
    repeat (2) step(1'b1, 3'b001, 3'b001);
    repeat (2) step(1'b1, 3'b000, 3'b000);

    // Zero pulse.
    cur_name = "zero";
    repeat (2) step(1'b1, 3'b010, 3'b010);
    repeat (2) step(1'b1, 3'b000, 3'b000);

    // Async reset with Cin=Bin held high across it.
    cur_name = "async_pre";
    repeat (5) step(1'b1, 3'b101, 3'b101);
    cur_name = "async_rst";
    repeat (5) step(1'b0, 3'b101, 3'b000);
    cur_name = "async_post";
    repeat (2) step(1'b1, 3'b101, 3'b101);
    step(1'b1, 3'b000, 3'b000);

    // All three flags together for a single edge.
    cur_name = "simul";
    step(1'b1, 3'b111, 3'b111);
    repeat (2) step(1'b1, 3'b000, 3'b000);

    // Reset asserted with every input high.
    cur_name = "rst_all_ones";
    step(1'b1, 3'b111, 3'b111);
    repeat (2) step(1'b0, 3'b111, 3'b000);
    step(1'b1, 3'b110, 3'b110);
    step(1'b1, 3'b011, 3'b011);

    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(posedge CLK);
      waited++;
    end
    #2;
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
